itof_wb_queue: RTL and testbench

//  Writeback side of the pipelined int-to-float converter (itof). Tracks the

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fpu_res_fifo.sv | 73 +++++++
 rtl/itof_wb_queue.sv | 120 ++++++++++++
 tb/tb_itof_wb_queue.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP-unit types for the itof writeback path.
//   FP_TAG_W   : destination FP register tag width
//   ITOF_LAT   : pipeline depth of the int-to-float converter
//   fp_tag_t   : destination tag
//   wb_entry_t : one buffered writeback (tag + float result)
package fpu_pkg;

  localparam int FP_TAG_W = 5;
  localparam int ITOF_LAT = 2;

  typedef logic [FP_TAG_W-1:0] fp_tag_t;

  typedef struct packed {
    fp_tag_t     tag;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/fpu_res_fifo.sv
// Synchronous result FIFO feeding the FP register-file writeback port.
// The head entry reads as zero while the FIFO is empty.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   flush      : synchronous clear of pointers and count (wins over push/pop)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : consume the head (ignored when empty)
//   head       : current head entry, zero when empty
//   valid      : FIFO not empty
//   count      : number of buffered entries
module fpu_res_fifo
  import fpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && valid && !flush;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = valid ? mem[rd_ptr] : '0;

  // The issue credit scheme must make this impossible.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !flush && count == (PW+1)'(DEPTH)));

endmodule

// File: rtl/itof_wb_queue.sv
// Writeback side of the pipelined int-to-float converter. Carries each issued
// op's destination tag down a delay line matching itof's latency, captures
// itof_y when the tag emerges, and buffers results for writeback. Because
// itof cannot stall, issue is throttled by credits: an op is only accepted
// when its result is guaranteed a FIFO slot.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   flush     : synchronous kill of all in-flight and buffered ops
//   x_valid   : op issued to itof this cycle
//   x_tag     : destination tag of the issued op
//   x_ready   : credit available (registered)
//   itof_y    : itof result bus
//   wb_valid  : FIFO head valid
//   wb_tag    : FIFO head tag (0 when empty)
//   wb_data   : FIFO head result (0 when empty)
//   wb_ready  : writeback consumes the head
module itof_wb_queue
  import fpu_pkg::*;
#(
  parameter int LAT   = ITOF_LAT,
  parameter int DEPTH = 4,
  parameter int TAG_W = FP_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             x_valid,
  input  logic [TAG_W-1:0] x_tag,
  output logic             x_ready,
  input  logic [31:0]      itof_y,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  input  logic             wb_ready
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } entry_t;

  // Wide enough to hold count + inflight, whose maximum is DEPTH + LAT.
  localparam int CW = $clog2(DEPTH + LAT + 1);
  localparam int FW = $clog2(DEPTH) + 1;

  logic [LAT-1:0]   dl_valid;
  logic [LAT-1:0]   dl_valid_next;
  logic [TAG_W-1:0] dl_tag [LAT];

  logic             accept;
  logic             push;
  logic             pop;
  entry_t           push_entry;
  entry_t           head;
  logic [FW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    inflight_next;
  logic             ready_next;

  assign accept     = x_valid && x_ready && !flush;
  assign push       = dl_valid[LAT-1] && !flush;
  assign pop        = wb_valid && wb_ready && !flush;
  assign push_entry = '{tag: dl_tag[LAT-1], data: itof_y};

  always_comb begin
    dl_valid_next    = '0;
    dl_valid_next[0] = accept;
    for (int i = 1; i < LAT; i++) dl_valid_next[i] = dl_valid[i-1];
    if (flush) dl_valid_next = '0;
  end

  // Tags shift unconditionally; only the valid bits decide what is captured.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dl_valid <= '0;
      for (int i = 0; i < LAT; i++) dl_tag[i] <= '0;
    end else begin
      dl_valid  <= dl_valid_next;
      dl_tag[0] <= x_tag;
      for (int i = 1; i < LAT; i++) dl_tag[i] <= dl_tag[i-1];
    end
  end

  // Credit is computed from the post-edge occupancy so x_ready can be a flop.
  always_comb begin
    count_next = CW'(count);
    if (flush)             count_next = '0;
    else if (push && !pop) count_next = count_next + CW'(1);
    else if (pop && !push) count_next = count_next - CW'(1);

    inflight_next = '0;
    for (int i = 0; i < LAT; i++) inflight_next = inflight_next + CW'(dl_valid_next[i]);

    ready_next = (count_next + inflight_next) < CW'(DEPTH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) x_ready <= 1'b1;
    else       x_ready <= ready_next;
  end

  fpu_res_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .valid     (wb_valid),
    .count     (count)
  );

  assign wb_tag  = head.tag;
  assign wb_data = head.data;

endmodule

// File: tb/tb_itof_wb_queue.sv
// Bench for itof_wb_queue. A behavioural itof pipeline drives itof_y; a
// queue-based model (in-flight list with ages, buffered list, credit bit)
// predicts the writeback outputs every cycle.
module tb_itof_wb_queue;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int OW    = TAG_W + 34;

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic             x_valid;
  logic [TAG_W-1:0] x_tag;
  logic             x_ready;
  logic [31:0]      x1;
  logic [31:0]      itof_y;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic             wb_ready;

  int errors = 0;
  int checks = 0;

  itof_wb_queue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .x_valid  (x_valid),
    .x_tag    (x_tag),
    .x_ready  (x_ready),
    .itof_y   (itof_y),
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag),
    .wb_data  (wb_data),
    .wb_ready (wb_ready)
  );

  always #5 clk = ~clk;

  // Signed int32 -> float32, round to nearest even.
  function automatic logic [31:0] itof_fn(input logic [31:0] x);
    logic        s;
    logic [31:0] mag, mant, rem, half;
    logic [7:0]  e;
    int          p, sh;
    if (x == 32'd0) return 32'd0;
    s   = x[31];
    mag = s ? (~x + 32'd1) : x;
    p   = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    e = 8'(127 + p);
    if (p <= 23) begin
      mant = mag << (23 - p);
    end else begin
      sh   = p - 23;
      mant = mag >> sh;
      rem  = mag & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        e    = e + 8'd1;
      end
    end
    return {s, e, mant[22:0]};
  endfunction

  // itof itself: fixed latency, never stalls, never reset.
  logic [31:0] ipipe [LAT];
  always @(posedge clk) begin
    ipipe[0] <= itof_fn(x1);
    for (int i = 1; i < LAT; i++) ipipe[i] <= ipipe[i-1];
  end
  assign itof_y = ipipe[LAT-1];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               age;
  } ent_t;

  ent_t m_fl[$];
  ent_t m_q[$];
  logic m_ready;

  logic [OW-1:0] dut_out;
  assign dut_out = {wb_valid, wb_tag, wb_data, x_ready};

  logic [OW-1:0] rst_out;
  assign rst_out = {1'b0, {TAG_W{1'b0}}, 32'd0, 1'b1};

  function automatic logic [OW-1:0] model_out();
    if (m_q.size() > 0) return {1'b1, m_q[0].tag, m_q[0].data, m_ready};
    return {1'b0, {TAG_W{1'b0}}, 32'd0, m_ready};
  endfunction

  function automatic void model_clear();
    m_q.delete();
    m_fl.delete();
    m_ready = 1'b1;
  endfunction

  // Drive one cycle at a negedge, advance the model across the coming edge,
  // and return at the next negedge.
  task automatic cycle(input logic v, input logic [TAG_W-1:0] tag, input logic [31:0] x,
                       input logic rdy, input logic fl);
    ent_t e;
    logic acc, pop;
    x_valid  = v;
    x_tag    = tag;
    x1       = x;
    wb_ready = rdy;
    flush    = fl;
    acc = v && m_ready && !fl;
    pop = (m_q.size() > 0) && rdy;
    if (fl) begin
      m_q.delete();
      m_fl.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      for (int i = 0; i < m_fl.size(); i++) m_fl[i].age = m_fl[i].age + 1;
      if (m_fl.size() > 0 && m_fl[0].age == LAT) begin
        e = m_fl.pop_front();
        m_q.push_back(e);
      end
      if (acc) begin
        e.tag  = tag;
        e.data = itof_fn(x);
        e.age  = 0;
        m_fl.push_back(e);
      end
    end
    m_ready = (m_q.size() + m_fl.size()) < DEPTH;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; x_valid = 1'b0; x_tag = '0; x1 = '0; wb_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if (dut_out !== rst_out) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", dut_out, rst_out);
    end
    rstn = 1'b1;
    cycle(0, TAG_W'($urandom), $urandom, 1, 0);
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", dut_out, model_out());
    end
  endtask

  task automatic test_single();
    cycle(1, 5'd3, 32'h0000_0005, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL single_model k=%0d: got %h want %h", k, dut_out, model_out());
      end
      checks++;
      if (wb_valid !== (k == 3)) begin
        errors++;
        $display("FAIL single_latency k=%0d: got wb_valid=%b want %b", k, wb_valid, (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (wb_tag !== 5'd3 || wb_data !== 32'h40A0_0000) begin
          errors++;
          $display("FAIL single_data: got tag=%0d data=%h want tag=3 data=40a00000", wb_tag, wb_data);
        end
      end
      cycle(0, TAG_W'($urandom), $urandom, 1, 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]      xs [3];
    logic [31:0]      ys [3];
    logic [TAG_W-1:0] ts [3];
    int acc;
    xs[0] = 32'hFFFF_FFFF; ys[0] = 32'hBF80_0000; ts[0] = 5'd10;
    xs[1] = 32'h8000_0000; ys[1] = 32'hCF00_0000; ts[1] = 5'd11;
    xs[2] = 32'h0100_0001; ys[2] = 32'h4B80_0000; ts[2] = 5'd12;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) cycle(1, ts[i], xs[i], 1, 0);
      else       cycle(0, TAG_W'($urandom), $urandom, 1, 0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL b2b_model i=%0d: got %h want %h", i, dut_out, model_out());
      end
      checks++;
      if (i >= 2 && i <= 4) begin
        if (wb_valid !== 1'b1 || wb_tag !== ts[i-2] || wb_data !== ys[i-2]) begin
          errors++;
          $display("FAIL b2b_seq i=%0d: got v=%b tag=%0d data=%h want v=1 tag=%0d data=%h",
                   i, wb_valid, wb_tag, wb_data, ts[i-2], ys[i-2]);
        end
      end else if (wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_seq i=%0d: got v=%b want v=0", i, wb_valid);
      end
    end
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (x_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_rate i=%0d: got x_ready=%b want 1", i, x_ready);
      end
      if (x_ready === 1'b1) acc++;
      cycle(1, TAG_W'(i), $urandom, 1, 0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL b2b_stream i=%0d: got %h want %h", i, dut_out, model_out());
      end
    end
    checks++;
    if (acc !== 20) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d want 20", acc);
    end
    repeat (4) begin
      cycle(0, TAG_W'($urandom), $urandom, 1, 0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL b2b_drain: got %h want %h", dut_out, model_out());
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [TAG_W-1:0] exp_tag;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (x_ready === 1'b1) acc++;
      cycle(1, TAG_W'(16 + i), $urandom, 0, 0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL bp_fill i=%0d: got %h want %h", i, dut_out, model_out());
      end
    end
    checks++;
    if (acc !== 4) begin
      errors++;
      $display("FAIL bp_accepts: got %0d want 4", acc);
    end
    checks++;
    if (x_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low: got %b want 0", x_ready);
    end
    exp_tag = 5'd16;
    for (int i = 0; i < 6; i++) begin
      if (wb_valid === 1'b1) begin
        checks++;
        if (wb_tag !== exp_tag) begin
          errors++;
          $display("FAIL bp_order: got tag=%0d want %0d", wb_tag, exp_tag);
        end
        exp_tag = exp_tag + 5'd1;
      end
      cycle(0, TAG_W'($urandom), $urandom, 1, 0);
      if (i == 0) begin
        checks++;
        if (x_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_recover: got %b want 1", x_ready);
        end
      end
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL bp_drain i=%0d: got %h want %h", i, dut_out, model_out());
      end
    end
    checks++;
    if (exp_tag !== 5'd20) begin
      errors++;
      $display("FAIL bp_popcount: got next tag %0d want 20", exp_tag);
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] held;
    cycle(1, 5'd1, $urandom, 0, 0);
    cycle(1, 5'd2, $urandom, 0, 0);
    cycle(1, 5'd4, $urandom, 0, 0);
    cycle(0, TAG_W'($urandom), $urandom, 0, 0);
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL pp_before: got %h want %h", dut_out, model_out());
    end
    cycle(0, TAG_W'($urandom), $urandom, 1, 0);
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL pp_model: got %h want %h", dut_out, model_out());
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_tag !== 5'd2 || x_ready !== 1'b1) begin
      errors++;
      $display("FAIL pp_head: got v=%b tag=%0d rdy=%b want v=1 tag=2 rdy=1", wb_valid, wb_tag, x_ready);
    end
    held = wb_data;
    cycle(0, TAG_W'($urandom), $urandom, 0, 0);
    checks++;
    if (wb_tag !== 5'd2 || wb_data !== held) begin
      errors++;
      $display("FAIL pp_stable: got tag=%0d data=%h want tag=2 data=%h", wb_tag, wb_data, held);
    end
    repeat (3) begin
      cycle(0, TAG_W'($urandom), $urandom, 1, 0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL pp_drain: got %h want %h", dut_out, model_out());
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) cycle(1, TAG_W'(5 + i), $urandom, 0, 0);
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL flush_before: got %h want %h", dut_out, model_out());
    end
    cycle(1, 5'd9, $urandom, 0, 1);
    checks++;
    if (wb_valid !== 1'b0 || x_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_next: got v=%b rdy=%b want v=0 rdy=1", wb_valid, x_ready);
    end
    cycle(1, 5'd9, $urandom, 1, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, TAG_W'($urandom), $urandom, 1, 0);
      checks++;
      if (dut_out !== model_out() || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_discard i=%0d: got %h want %h", i, dut_out, model_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    cycle(1, 5'd11, $urandom, 1, 0);
    cycle(1, 5'd12, $urandom, 1, 0);
    cycle(1, 5'd13, $urandom, 0, 0);
    x_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (dut_out !== rst_out) begin
      errors++;
      $display("FAIL rst_mid_async: got %h want %h", dut_out, rst_out);
    end
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    cycle(1, 5'd21, 32'd7, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL rst_mid_model i=%0d: got %h want %h", i, dut_out, model_out());
      end
      if (wb_valid === 1'b1) begin
        found = 1'b1;
        checks++;
        if (wb_tag !== 5'd21 || wb_data !== 32'h40E0_0000) begin
          errors++;
          $display("FAIL rst_mid_first: got tag=%0d data=%h want tag=21 data=40e00000", wb_tag, wb_data);
        end
      end
      cycle(0, TAG_W'($urandom), $urandom, 1, 0);
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_timeout: got no writeback want tag 21");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, TAG_W'($urandom), $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL random i=%0d: got %h want %h", i, dut_out, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_push_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
